// File: rtl/rv32i_multicycle_sequencer_if.sv
// Handshake bundle between the multi-cycle sequencer and the instruction/data memories.
interface rv32i_multicycle_sequencer_if;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic        dmem_ready;
    logic        dmem_req;

    modport master (
        input  imem_rdata,
        input  imem_ready,
        output imem_req,
        input  dmem_ready,
        output dmem_req
    );

    modport slave (
        output imem_rdata,
        output imem_ready,
        input  imem_req,
        output dmem_ready,
        input  dmem_req
    );
endinterface

// File: rtl/rv32i_multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: fetch into IR, then sequence ALU, memory and write-back phases.
// Optional memory-wait timeout is enabled by defining SEQ_MEM_TIMEOUT_EN.
module rv32i_multicycle_sequencer #(
    parameter bit          RESET_STATE_FETCH = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES    = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    rv32i_multicycle_sequencer_if.master        mem,
    output logic [31:0]                         ir,
    output logic                                PC_WE,
    output logic                                RegWE,
    output logic [3:0]                          ALU_control,
    output logic                                Imm_mux_SEL,
    output logic                                MemRW,
    output logic                                WB_sel,
    output logic                                illegal,
    output logic                                timeout
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StMem, StWriteback, StHalt
    } state_e;

    localparam state_e     ResetState = RESET_STATE_FETCH ? StFetch : StIdle;
    localparam logic [6:0] OpR        = 7'b0110011;
    localparam logic [6:0] OpImm      = 7'b0010011;
    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpStore    = 7'b0100011;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic        imem_req_c;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_load, is_store;
    logic        legal;
    logic        ex_phase;
    logic [3:0]  alu_dec;

    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign is_r     = (opcode == OpR);
    assign is_i     = (opcode == OpImm);
    assign is_load  = (opcode == OpLoad);
    assign is_store = (opcode == OpStore);
    assign ex_phase = (state_q == StExecute) || (state_q == StMem) || (state_q == StWriteback);

    // Decode is purely a function of IR so ALU_control stays stable across multi-cycle phases.
    always_comb begin
        alu_dec = 4'b0000;
        legal   = 1'b0;
        case (opcode)
            OpR, OpImm: begin
                legal = 1'b1;
                unique case (funct3)
                    3'b000: alu_dec = (is_r && ir_q[30]) ? 4'b0001 : 4'b0000;
                    3'b001: alu_dec = 4'b0010;
                    3'b010: alu_dec = 4'b0011;
                    3'b011: alu_dec = 4'b0100;
                    3'b100: alu_dec = 4'b0101;
                    3'b101: alu_dec = ir_q[30] ? 4'b0111 : 4'b0110;
                    3'b110: alu_dec = 4'b1000;
                    3'b111: alu_dec = 4'b1001;
                endcase
            end
            OpLoad: begin
                case (funct3)
                    3'b000:  begin legal = 1'b1; alu_dec = 4'b1010; end
                    3'b001:  begin legal = 1'b1; alu_dec = 4'b1011; end
                    3'b010:  begin legal = 1'b1; alu_dec = 4'b1100; end
                    3'b100:  begin legal = 1'b1; alu_dec = 4'b1101; end
                    3'b101:  begin legal = 1'b1; alu_dec = 4'b1110; end
                    default: legal = 1'b0;
                endcase
            end
            OpStore: legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            default: legal = 1'b0;
        endcase
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        illegal_d   = illegal_q;
        imem_req_c  = 1'b0;
        mem.dmem_req = 1'b0;
        PC_WE       = 1'b0;
        RegWE       = 1'b0;
        ALU_control = 4'b0000;
        Imm_mux_SEL = 1'b0;
        MemRW       = 1'b0;
        WB_sel      = 1'b0;

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_d    = mem.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExecute;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end
            end
            StExecute: state_d = (is_load || is_store) ? StMem : StWriteback;
            StMem: begin
                mem.dmem_req = 1'b1;
                MemRW        = is_store;
                if (mem.dmem_ready) begin
                    if (is_store) begin
                        PC_WE   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end
            end
            StWriteback: begin
                RegWE   = (ir_q[11:7] != 5'd0);
                WB_sel  = is_load;
                PC_WE   = 1'b1;
                state_d = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = ResetState;
        endcase

        if (ex_phase) begin
            ALU_control = alu_dec;
            Imm_mux_SEL = is_i || is_load || is_store;
        end

`ifdef SEQ_MEM_TIMEOUT_EN
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if ((state_q == StFetch && !mem.imem_ready) || (state_q == StMem && !mem.dmem_ready)) begin
            wait_d = wait_q + 8'd1;
            if (wait_d == TimeoutLimit) begin
                timeout_d = 1'b1;
                state_d   = StHalt;
            end
        end
        if ((state_d != state_q) && (state_d == StFetch || state_d == StMem)) begin
            wait_d = 8'd0;
        end
`endif
    end

    // Gate the fetch request so a FETCH reset state cannot request while rst_n is held low.
    assign mem.imem_req = imem_req_c & rst_n;
    assign ir           = ir_q;
    assign illegal      = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ResetState;
            ir_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_sequencer.sv
// Scoreboard bench for rv32i_multicycle_sequencer: expectations queued per instruction,
// popped and compared on each PC_WE pulse.
module tb_rv32i_multicycle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] ir;
    logic        pc_we, reg_we, imm_sel, mem_rw, wb_sel, illegal, timeout;
    logic [3:0]  alu_ctl;

    rv32i_multicycle_sequencer_if mem_if ();

    rv32i_multicycle_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (mem_if),
        .ir          (ir),
        .PC_WE       (pc_we),
        .RegWE       (reg_we),
        .ALU_control (alu_ctl),
        .Imm_mux_SEL (imm_sel),
        .MemRW       (mem_rw),
        .WB_sel      (wb_sel),
        .illegal     (illegal),
        .timeout     (timeout)
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic        imm;
        logic        rwe;
        logic        wbs;
        logic        mrw;
        int          lat;
        int          ireq;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   iwait_cfg = 0, dwait_cfg = 0;
    int   icnt = 0, dcnt = 0;
    int   cyc = 0, ireq = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: ready after the configured number of wait cycles, noise when idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            icnt = 0;
            dcnt = 0;
            mem_if.imem_ready = 1'b0;
            mem_if.dmem_ready = 1'b0;
        end else begin
            if (mem_if.imem_req) begin
                mem_if.imem_ready = (icnt == iwait_cfg);
                icnt = (icnt == iwait_cfg) ? 0 : icnt + 1;
            end else begin
                mem_if.imem_ready = 1'($urandom_range(0, 1));
                icnt = 0;
            end
            if (mem_if.dmem_req) begin
                mem_if.dmem_ready = (dcnt == dwait_cfg);
                dcnt = (dcnt == dwait_cfg) ? 0 : dcnt + 1;
            end else begin
                mem_if.dmem_ready = 1'($urandom_range(0, 1));
                dcnt = 0;
            end
        end
    end

    // Monitor samples after the responder has settled the ready inputs.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            cyc  = 0;
            ireq = 0;
        end else begin
            cyc++;
            if (mem_if.imem_req) ireq++;
            if (pc_we || reg_we) check_eq("strobe_vs_imem_req", mem_if.imem_req, 0);
            if (reg_we) check_eq("regwe_with_pcwe", pc_we, 1);
            if (mem_if.dmem_req) begin
                check_eq("sb_empty_on_dmem_req", 32'(sb.size() == 0), 0);
                if (sb.size() > 0) begin
                    check_eq("mem_rw", mem_rw, sb[0].mrw);
                    check_eq("mem_alu", alu_ctl, sb[0].alu);
                    check_eq("mem_imm", imm_sel, sb[0].imm);
                end
            end
            if (pc_we) begin
                check_eq("sb_empty_on_pc_we", 32'(sb.size() == 0), 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("ir", ir, e.instr);
                    check_eq("reg_we", reg_we, e.rwe);
                    check_eq("wb_sel", wb_sel, e.wbs);
                    check_eq("alu", alu_ctl, e.alu);
                    check_eq("imm_sel", imm_sel, e.imm);
                    check_eq("latency", cyc, e.lat);
                    check_eq("imem_req_cycles", ireq, e.ireq);
                end
                cyc  = 0;
                ireq = 0;
            end
        end
    end

    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic [3:0] alu, input logic imm, input logic rwe,
                             input logic wbs, input logic mrw, input int lat);
        exp_t x;
        x.instr = instr; x.alu = alu; x.imm = imm; x.rwe = rwe;
        x.wbs = wbs; x.mrw = mrw; x.lat = lat; x.ireq = iw + 1;
        sb.push_back(x);
        mem_if.imem_rdata = instr;
        iwait_cfg = iw;
        dwait_cfg = dw;
        for (int n = 0; n < 60 && sb.size() != 0; n++) begin
            @(negedge clk);
            #3;
        end
        check_eq("instr_done", 32'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic expect_illegal(input logic [31:0] instr, input string tag);
        int req_cycles;
        mem_if.imem_rdata = instr;
        iwait_cfg = 0;
        for (int n = 0; n < 20 && !illegal; n++) begin
            @(negedge clk);
            #3;
        end
        check_eq({tag, "_illegal"}, illegal, 1);
        check_eq({tag, "_ir"}, ir, instr);
        req_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            #3;
            if (mem_if.imem_req || pc_we || reg_we) req_cycles++;
        end
        check_eq({tag, "_quiet_in_halt"}, req_cycles, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_if.imem_rdata = 32'h002081B3;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_imem_req", mem_if.imem_req, 0);
        check_eq("rst_dmem_req", mem_if.dmem_req, 0);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_pc_we", pc_we, 0);
        check_eq("rst_reg_we", reg_we, 0);
        check_eq("rst_mem_rw", mem_rw, 0);
        check_eq("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        //        instr         iw dw alu      imm  rwe  wbs  mrw  lat
        run_instr(32'h002081B3, 0, 0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4); // add
        run_instr(32'h402081B3, 1, 0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 5); // sub
        run_instr(32'h0040A283, 0, 2, 4'b1100, 1'b1, 1'b1, 1'b1, 1'b0, 7); // lw
        run_instr(32'h0050A423, 0, 0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4); // sw
        run_instr(32'h0050A423, 2, 1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 7); // sw, waits
        run_instr(32'h00100013, 0, 0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4); // addi x0
        run_instr(32'h4030D093, 0, 0, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 4); // srai
        run_instr(32'h40000093, 0, 0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4); // addi bit30
        run_instr(32'h00317233, 0, 0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 4); // and
        run_instr(32'h0020B2B3, 0, 0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4); // sltu
        run_instr(32'h00014303, 1, 0, 4'b1101, 1'b1, 1'b1, 1'b1, 1'b0, 6); // lbu
        run_instr(32'h00209383, 0, 0, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 5); // lh

        expect_illegal(32'h0000007F, "op7f");

        rst_n = 1'b0;
        #1;
        check_eq("illegal_cleared", illegal, 0);
        mem_if.imem_rdata = 32'h0040A283;
        release_reset();

        // Hold a load in MEM, then pull reset mid-access.
        sb.push_back('{32'h0040A283, 4'b1100, 1'b1, 1'b1, 1'b1, 1'b0, 99, 1});
        iwait_cfg = 0;
        dwait_cfg = 30;
        for (int n = 0; n < 20 && !mem_if.dmem_req; n++) begin
            @(negedge clk);
            #3;
        end
        check_eq("reached_mem", mem_if.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midmem_dmem_req", mem_if.dmem_req, 0);
        check_eq("midmem_imem_req", mem_if.imem_req, 0);
        check_eq("midmem_alu", alu_ctl, 4'b0000);
        check_eq("midmem_imm", imm_sel, 0);
        check_eq("midmem_reg_we", reg_we, 0);
        check_eq("midmem_ir", ir, 32'd0);
        mem_if.imem_rdata = 32'h002081B3;
        release_reset();

        run_instr(32'h002081B3, 0, 0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4); // add after reset
        expect_illegal(32'h0050B423, "store_f3_011");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_sequencer.md
Name: rv32i_multicycle_sequencer

Overview:
Multi-cycle control FSM for the RV32I core. It replaces the single-cycle decode-only control path with a sequenced one: it fetches through a ready/valid instruction port, holds the instruction in an internal IR, and steps the shared ALU, register file and data memory through per-class phases. It sits between the instruction/data memory interfaces and the existing datapath, and drives the same control encodings the datapath already consumes.

Parameters:
RESET_STATE_FETCH, 1, 1 = leave reset directly in FETCH; 0 = one idle cycle first
TIMEOUT_CYCLES, 64, memory wait limit; used only with the optional feature

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_rdata  input  32  instruction word
imem_ready  input  1  instruction fetch complete this cycle
imem_req  output  1  fetch request
dmem_ready  input  1  data access complete this cycle
dmem_req  output  1  data access request
ir  output  32  latched instruction, feeds rs1/rs2/rd/imm extraction
PC_WE  output  1  PC update strobe
RegWE  output  1  register file write enable
ALU_control  output  4  0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and, 1010 LB, 1011 LH, 1100 LW, 1101 LBU, 1110 LHU
Imm_mux_SEL  output  1  1 = immediate operand B
MemRW  output  1  0 = read, 1 = write
WB_sel  output  1  1 = memory data to register file
illegal  output  1  sticky: unsupported opcode/funct3 seen
timeout  output  1  sticky: memory wait exceeded (optional feature only)

Behaviour:
- Reset (async, rst_n=0): state IDLE or FETCH per RESET_STATE_FETCH; ir=0; all outputs 0; MemRW=0. Reset mid-access abandons the request with no write-back.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. IDLE always goes to FETCH after 1 cycle.
- FETCH: imem_req=1. Hold the state until imem_ready=1; in that cycle latch ir<=imem_rdata and go to DECODE.
- DECODE (1 cycle): supported opcodes are 0110011 (R), 0010011 (I-ALU), 0000011 (load: funct3 000/001/010/100/101) and 0100011 (store: funct3 000/001/010). Any other opcode/funct3 sets illegal=1 and goes to HALT. Otherwise go to EXECUTE.
- ALU_control is valid from EXECUTE through WRITEBACK/MEM and derives only from ir.
  - R: instr[30] selects add/sub and srl/sra.
  - I-ALU: funct3 000 is always add; 101 uses instr[30].
  - Loads: codes 1010–1110. Stores: add.
- Imm_mux_SEL=1 for I-ALU, load and store, in EXECUTE/MEM/WRITEBACK.
- EXECUTE (1 cycle): R/I go to WRITEBACK; load/store go to MEM.
- MEM: dmem_req=1; MemRW=1 for store, 0 for load. Hold until dmem_ready=1.
  - Load goes to WRITEBACK.
  - Store asserts PC_WE=1 in the ready cycle and goes to FETCH.
- WRITEBACK (1 cycle): RegWE=1 unless ir[11:7]==0; WB_sel=1 for load; PC_WE=1; go to FETCH.
- HALT: all strobes 0 until reset; illegal stays 1.
- PC_WE and RegWE are single-cycle pulses, never high in the same cycle as imem_req.
- Zero-wait latency: R/I 4 cycles, store 4 cycles, load 5 cycles. Each memory wait cycle adds 1.
- imem_ready/dmem_ready outside FETCH/MEM are ignored.

Optional Feature:
SEQ_MEM_TIMEOUT_EN:
- Defined: an 8-bit wait counter clears on entry to FETCH/MEM and increments each non-ready cycle. When it reaches TIMEOUT_CYCLES, set timeout=1, drop the request, and go to HALT.
- Undefined: no counter; timeout tied to 0; waits are unbounded.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_ready immediate -> imem_req 1 cycle, ALU_control=0000, RegWE pulse in cycle 4 with PC_WE; sub 0x402081B3 -> 0001.
- lw x5,4(x1) (0x0040A283), dmem_ready after 2 wait cycles -> MemRW=0, ALU_control=1100, Imm_mux_SEL=1, RegWE+WB_sel in cycle 7.
- sw x5,8(x1) (0x0050A423) -> MemRW=1 during MEM, no RegWE, PC_WE on dmem_ready, back to FETCH.
- addi x0,x0,1 (0x00100013) -> RegWE stays 0, PC_WE pulses; opcode 0x7F -> illegal=1, HALT, no further imem_req.
- rst_n low while in MEM with dmem_req=1 -> outputs 0 immediately; after release, fetch restarts.
- SEQ_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, imem_ready held 0 -> timeout=1 after 8 wait cycles, imem_req drops.
